// File: rtl/rect_stream_tx_pkg.sv
// Shared sizes, slot field offsets and FSM encoding for the rectangle stream transmitter.
package rect_stream_tx_pkg;

    localparam int unsigned RECT_NUMMAX       = 16;
    localparam int unsigned RECT_NUMMAX_WIDTH = 4;
    localparam int unsigned SLOT_W            = 32;

    localparam int unsigned X1_OFF = 24;
    localparam int unsigned Y1_OFF = 16;
    localparam int unsigned X2_OFF = 8;
    localparam int unsigned Y2_OFF = 0;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StSend,
        StDone
    } tx_state_e;

    function automatic logic [7:0] slot_field(input logic [SLOT_W-1:0] slot,
                                              input int unsigned off);
        return slot[off +: 8];
    endfunction

endpackage

// File: rtl/rect_list_buf.sv
// Working and shadow storage for a captured rectangle list, with capture/promote control
// and the overrun flag raised when a pending shadow list is replaced.
module rect_list_buf
    import rect_stream_tx_pkg::*;
#(
    parameter int unsigned RECT_NUM = RECT_NUMMAX
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       i_finish,
    input  logic [RECT_NUM*SLOT_W-1:0] i_item,
    input  logic                       i_idle,
    output logic                       o_load,
    output logic [RECT_NUM*SLOT_W-1:0] o_data,
    output logic [RECT_NUM-1:0]        o_mask,
    output logic                       o_overrun
);

    logic [RECT_NUM*SLOT_W-1:0] r_data;
    logic [RECT_NUM-1:0]        r_mask;
    logic [RECT_NUM*SLOT_W-1:0] r_shadow_data;
    logic [RECT_NUM-1:0]        r_shadow_mask;
    logic                       r_shadow_full;
    logic                       r_overrun;

    logic [RECT_NUM-1:0] w_mask;
    logic                w_promote;
    logic                w_capture;
    logic                w_shadow_wr;

    // Slot 0 is never a real rectangle, so its valid bit is forced low.
    always_comb begin
        w_mask = '0;
        for (int k = 1; k < RECT_NUM; k++) begin
            w_mask[k] = |i_item[k*SLOT_W +: SLOT_W];
        end
    end

    assign w_promote   = i_idle & r_shadow_full;
    assign w_capture   = i_idle & ~r_shadow_full & i_finish;
    assign w_shadow_wr = i_finish & ~w_capture;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_data <= '0;
            r_mask <= '0;
        end else if (w_promote) begin
            r_data <= r_shadow_data;
            r_mask <= r_shadow_mask;
        end else if (w_capture) begin
            r_data <= i_item;
            r_mask <= w_mask;
        end
    end

    // A promote in the same cycle as a new list consumes the old shadow, so nothing is lost.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shadow_data <= '0;
            r_shadow_mask <= '0;
            r_shadow_full <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= w_shadow_wr & r_shadow_full & ~w_promote;
            if (w_shadow_wr) begin
                r_shadow_data <= i_item;
                r_shadow_mask <= w_mask;
                r_shadow_full <= 1'b1;
            end else if (w_promote) begin
                r_shadow_full <= 1'b0;
            end
        end
    end

    assign o_load    = w_promote | w_capture;
    assign o_data    = r_data;
    assign o_mask    = r_mask;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/rect_stream_tx.sv
// Serialises a packed rectangle list into one valid/ready beat per non-empty slot,
// with end-of-list done/count reporting.
module rect_stream_tx
    import rect_stream_tx_pkg::*;
#(
    parameter int unsigned RECT_NUM = RECT_NUMMAX,
    parameter int unsigned R_W      = RECT_NUMMAX_WIDTH
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       i_finish,
    input  logic [RECT_NUM*SLOT_W-1:0] i_item,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [7:0]                 o_x1,
    output logic [7:0]                 o_y1,
    output logic [7:0]                 o_x2,
    output logic [7:0]                 o_y2,
    output logic [R_W-1:0]             o_index,
    output logic                       o_last,
    output logic                       o_done,
    output logic [R_W:0]               o_count,
    output logic                       o_busy,
    output logic                       o_overrun
);

    localparam logic [R_W-1:0] LAST_IDX = R_W'(RECT_NUM - 1);
    localparam logic [R_W-1:0] ONE_IDX  = R_W'(1);
    localparam logic [R_W:0]   ONE_CNT  = (R_W + 1)'(1);

    tx_state_e r_state;
    tx_state_e w_state_next;

    logic [R_W-1:0] r_idx;
    logic [R_W:0]   r_cnt;
    logic           r_valid;
    logic [7:0]     r_x1;
    logic [7:0]     r_y1;
    logic [7:0]     r_x2;
    logic [7:0]     r_y2;
    logic [R_W-1:0] r_index;
    logic           r_last;

    logic                       w_load;
    logic [RECT_NUM*SLOT_W-1:0] w_data;
    logic [RECT_NUM-1:0]        w_mask;
    logic [SLOT_W-1:0]          w_slot;
    logic                       w_hit;
    logic                       w_rest_empty;
    logic                       w_handshake;
    logic                       w_idle;

    rect_list_buf #(
        .RECT_NUM (RECT_NUM)
    ) u_buf (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_finish  (i_finish),
        .i_item    (i_item),
        .i_idle    (w_idle),
        .o_load    (w_load),
        .o_data    (w_data),
        .o_mask    (w_mask),
        .o_overrun (o_overrun)
    );

    assign w_idle      = (r_state == StIdle);
    assign w_slot      = w_data[r_idx*SLOT_W +: SLOT_W];
    assign w_hit       = w_mask[r_idx];
    assign w_handshake = (r_state == StSend) & r_valid & i_ready;

    // Current slot is the last one when no higher slot holds a rectangle.
    always_comb begin
        w_rest_empty = 1'b1;
        for (int k = 0; k < RECT_NUM; k++) begin
            if ((k > int'(r_idx)) && w_mask[k]) begin
                w_rest_empty = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_load) begin
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (w_hit) begin
                    w_state_next = StSend;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = StDone;
                end
            end
            StSend: begin
                if (w_handshake) begin
                    w_state_next = r_last ? StDone : StScan;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        o_busy  = (r_state != StIdle);
        o_done  = (r_state == StDone);
        o_count = o_done ? r_cnt : '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx <= ONE_IDX;
            r_cnt <= '0;
        end else if (w_idle && w_load) begin
            r_idx <= ONE_IDX;
            r_cnt <= '0;
        end else if ((r_state == StScan) && !w_hit && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + ONE_IDX;
        end else if (w_handshake) begin
            r_cnt <= r_cnt + ONE_CNT;
            if (!r_last) begin
                r_idx <= r_idx + ONE_IDX;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_valid <= 1'b0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_x2    <= '0;
            r_y2    <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if ((r_state == StScan) && w_hit) begin
            r_valid <= 1'b1;
            r_x1    <= slot_field(w_slot, X1_OFF);
            r_y1    <= slot_field(w_slot, Y1_OFF);
            r_x2    <= slot_field(w_slot, X2_OFF);
            r_y2    <= slot_field(w_slot, Y2_OFF);
            r_index <= r_idx;
            r_last  <= w_rest_empty;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_x1    = r_x1;
    assign o_y1    = r_y1;
    assign o_x2    = r_x2;
    assign o_y2    = r_y2;
    assign o_index = r_index;
    assign o_last  = r_last;

endmodule

// File: tb/tb_rect_stream_tx.sv
// Directed bench for rect_stream_tx: a list-level model predicts beats and counts,
// and a negedge monitor checks every handshake, hold and done against it.
module tb_rect_stream_tx;
    import rect_stream_tx_pkg::*;

    localparam int N = 16;
    localparam int W = 4;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             i_finish  = 1'b0;
    logic             i_ready   = 1'b0;
    logic [N*32-1:0]  i_item    = '0;
    logic             o_valid;
    logic [7:0]       o_x1, o_y1, o_x2, o_y2;
    logic [W-1:0]     o_index;
    logic             o_last, o_done, o_busy, o_overrun;
    logic [W:0]       o_count;

    rect_stream_tx #(
        .RECT_NUM (N),
        .R_W      (W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_finish  (i_finish),
        .i_item    (i_item),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_x1      (o_x1),
        .o_y1      (o_y1),
        .o_x2      (o_x2),
        .o_y2      (o_y2),
        .o_index   (o_index),
        .o_last    (o_last),
        .o_done    (o_done),
        .o_count   (o_count),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] idx;
        logic [31:0]  rect;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_cnt_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    int    beat_cnt  = 0;
    int    done_cnt  = 0;
    int    ovr_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Expected beats of a list: every non-empty slot 1..N-1 in order, last on the highest.
    function automatic void model_list(input logic [N*32-1:0] lst);
        int    hi;
        int    n;
        beat_t b;
        hi = 0;
        n  = 0;
        for (int k = 1; k < N; k++) begin
            if (lst[k*32 +: 32] != 32'h0) hi = k;
        end
        for (int k = 1; k < N; k++) begin
            if (lst[k*32 +: 32] != 32'h0) begin
                b.idx  = W'(k);
                b.rect = lst[k*32 +: 32];
                b.last = (k == hi);
                exp_q.push_back(b);
                n++;
            end
        end
        exp_cnt_q.push_back(n);
    endfunction

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
        end
    end

    initial begin
        logic        held;
        logic [63:0] held_v;
        logic [63:0] cur_v;
        beat_t       b;
        int          c;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                held = 1'b0;
            end else begin
                cur_v = 64'({o_valid, o_index, o_x1, o_y1, o_x2, o_y2, o_last});
                if (held) chk("hold_stable", cur_v, held_v);
                held = 1'b0;
                if (o_valid) begin
                    if (i_ready) begin
                        beat_cnt++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat: got idx=%0d required no beat", o_index);
                        end else begin
                            b = exp_q.pop_front();
                            chk("beat", 64'({o_index, o_x1, o_y1, o_x2, o_y2, o_last}),
                                64'({b.idx, b.rect, b.last}));
                        end
                    end else begin
                        held   = 1'b1;
                        held_v = cur_v;
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    if (exp_cnt_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got count=%0d required no done", o_count);
                    end else begin
                        c = exp_cnt_q.pop_front();
                        chk("done_count", 64'(o_count), 64'(c));
                    end
                end
                if (o_overrun) ovr_cnt++;
            end
        end
    end

    task automatic pulse(input logic [N*32-1:0] lst, output int cap);
        @(posedge sys_clk);
        #1;
        i_item   = lst;
        i_finish = 1'b1;
        @(posedge sys_clk);
        #1;
        cap      = cyc;
        i_finish = 1'b0;
    endtask

    // Latencies count cycles after the capture edge: 1 = the cycle right after it.
    task automatic wait_valid(input int cap, input int maxc, output int lat);
        lat = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge sys_clk);
            if (o_valid) begin
                lat = cyc - cap + 1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int cap, input int maxc, output int lat);
        lat = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge sys_clk);
            if (o_done) begin
                lat = cyc - cap + 1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int maxc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && exp_cnt_q.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({o_valid, o_index, o_x1, o_y1, o_x2, o_y2, o_last,
                       o_done, o_count, o_busy, o_overrun}), 64'h0);
    endtask

    initial begin
        logic [N*32-1:0] l1, l4, lb, lc;
        int cap, lat, b0, d0, o0;

        l1 = '0;
        l1[3*32 +: 32] = 32'h1C00_2004;
        l1[7*32 +: 32] = 32'h2C08_3410;
        l4 = '0;
        l4[0*32 +: 32]  = 32'hFFFF_FFFF;
        l4[1*32 +: 32]  = 32'h0102_0304;
        l4[15*32 +: 32] = 32'hA0B0_C0D0;
        lb = '0;
        lb[5*32 +: 32] = 32'h5555_5555;
        lc = '0;
        lc[2*32 +: 32] = 32'h0A0B_0C0D;
        lc[9*32 +: 32] = 32'h9091_9293;

        repeat (3) @(posedge sys_clk);
        #1;
        chk_all_zero("reset_outputs");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk_all_zero("post_reset_idle");

        // Two-beat list, consumer always ready.
        i_ready = 1'b1;
        model_list(l1);
        pulse(l1, cap);
        wait_valid(cap, 40, lat);
        chk("t1_first_latency", 64'(lat), 64'(4));
        chk("t1_beat0_fields", 64'({o_x1, o_y1, o_x2, o_y2}), 64'({8'd28, 8'd0, 8'd32, 8'd4}));
        chk("t1_beat0_index", 64'(o_index), 64'(3));
        chk("t1_beat0_last", 64'(o_last), 64'(0));
        wait_valid(cap, 40, lat);
        wait_done(cap, 40, lat);
        chk("t1_done_latency", 64'(lat), 64'(10));
        chk("t1_done_count", 64'(o_count), 64'(2));
        wait_drain("t1_drain", 100);

        // Empty list.
        b0 = beat_cnt;
        model_list('0);
        pulse('0, cap);
        wait_done(cap, 40, lat);
        chk("t2_done_latency", 64'(lat), 64'(16));
        chk("t2_done_count", 64'(o_count), 64'(0));
        wait_drain("t2_drain", 100);
        chk("t2_no_beats", 64'(beat_cnt - b0), 64'(0));

        // Back-pressure on the first beat.
        i_ready = 1'b0;
        b0 = beat_cnt;
        model_list(l1);
        pulse(l1, cap);
        wait_valid(cap, 40, lat);
        chk("t3_first_latency", 64'(lat), 64'(4));
        repeat (5) @(posedge sys_clk);
        #1;
        chk("t3_still_valid", 64'({o_valid, o_index}), 64'({1'b1, 4'd3}));
        i_ready = 1'b1;
        wait_drain("t3_drain", 100);
        chk("t3_beats", 64'(beat_cnt - b0), 64'(2));

        // Slot 0 junk is ignored; slots 1 and 15 stream.
        b0 = beat_cnt;
        model_list(l4);
        pulse(l4, cap);
        wait_valid(cap, 40, lat);
        chk("t4_first_latency", 64'(lat), 64'(2));
        chk("t4_first_index", 64'(o_index), 64'(1));
        wait_drain("t4_drain", 100);
        chk("t4_beats", 64'(beat_cnt - b0), 64'(2));

        // A streams, B lands in the shadow, C overwrites B; expect A then C.
        o0 = ovr_cnt;
        b0 = beat_cnt;
        model_list(l1);
        model_list(lc);
        pulse(l1, cap);
        repeat (2) @(posedge sys_clk);
        pulse(lb, cap);
        pulse(lc, cap);
        wait_drain("t5_drain", 200);
        chk("t5_overrun_pulses", 64'(ovr_cnt - o0), 64'(1));
        chk("t5_beats", 64'(beat_cnt - b0), 64'(4));

        // Reset while a beat is waiting for the consumer.
        i_ready = 1'b0;
        model_list(l1);
        pulse(l1, cap);
        wait_valid(cap, 40, lat);
        chk("t6_valid_before_reset", 64'(o_valid), 64'(1));
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        exp_q.delete();
        exp_cnt_q.delete();
        #1;
        chk_all_zero("t6_reset_outputs");
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        i_ready   = 1'b1;
        b0 = beat_cnt;
        d0 = done_cnt;
        repeat (40) @(posedge sys_clk);
        #1;
        chk("t6_no_beats_after_reset", 64'(beat_cnt - b0), 64'(0));
        chk("t6_no_done_after_reset", 64'(done_cnt - d0), 64'(0));
        chk("t6_idle_after_reset", 64'(o_busy), 64'(0));
        model_list(l4);
        pulse(l4, cap);
        wait_drain("t6_recover_drain", 100);
        chk("t6_recover_beats", 64'(beat_cnt - b0), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
